unsigned_divider_16by8_seq: RTL

Sequential unsigned restoring divider that inverts the 8x8 unsigned multipliers: it takes a 16-bit product-width dividend `z` and an 8-bit divisor `y`, and returns the 8-bit quotient `x` and the 8-bit remainder `r`. It sits downstream of the multiplier array. Error-characterisation benches use it to recover operands from exact or approximate products. Datapaths use it where a multiply must be undone. It uses one restoring iteration per cycle behind a start/done handshake.

---
 rtl/unsigned_divider_16by8_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/unsigned_divider_16by8_seq.sv
// unsigned_divider_16by8_seq
// Sequential unsigned restoring divider: 16-bit dividend z, 8-bit divisor y,
// 8-bit quotient x and 8-bit remainder r, one restoring step per clock.
// An accepted request whose quotient cannot fit in 8 bits (including y == 0)
// finishes immediately with ovf = 1 and x = r = 8'hFF.
// Optional feature: define DIV_TRUNC2_EN to drop the two low dividend bits
// and run 6 iterations, so x = floor(z / (4y)) << 2 and r is the remainder
// of that reduced division (floor(R/4) of the full-width partial remainder).
module unsigned_divider_16by8_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] z,
   input  logic [7:0]  y,
   output logic        busy,
   output logic        done,
   output logic [7:0]  x,
   output logic [7:0]  r,
   output logic        ovf
);

`ifdef DIV_TRUNC2_EN
   localparam int ITERS = 6;
   localparam int QW    = 6;
`else
   localparam int ITERS = 8;
   localparam int QW    = 8;
`endif

   localparam logic [2:0] LAST_CNT = 3'(ITERS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [7:0]      div_reg;
   logic [7:0]      a;
   logic [QW-1:0]   q;
   logic [2:0]      cnt;

   logic [8:0]      shifted;
   logic [8:0]      diff;
   logic            fits;
   logic [7:0]      a_next;
   logic [QW-1:0]   q_next;
   logic [7:0]      x_next;

   // One restoring step: shift {A,Q} left, subtract the divisor when it fits.
   // The partial remainder stays below the divisor, so after the subtract (or
   // when no subtract happens) it always fits back into 8 bits.
   always_comb begin
      shifted = 9'd0;
      diff    = 9'd0;
      fits    = 1'b0;
      a_next  = 8'd0;
      q_next  = '0;
      x_next  = 8'd0;
      shifted = {a, q[QW-1]};
      diff    = shifted - {1'b0, div_reg};
      fits    = (shifted >= {1'b0, div_reg});
      a_next  = fits ? diff[7:0] : shifted[7:0];
      q_next  = {q[QW-2:0], fits};
`ifdef DIV_TRUNC2_EN
      x_next  = {q_next, 2'b00};
`else
      x_next  = q_next;
`endif
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         x       <= 8'd0;
         r       <= 8'd0;
         ovf     <= 1'b0;
         cnt     <= 3'd0;
         a       <= 8'd0;
         q       <= '0;
         div_reg <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  div_reg <= y;
                  a       <= z[15:8];
                  q       <= z[7:8-QW];
                  cnt     <= 3'd0;
                  busy    <= 1'b1;
                  if (z[15:8] >= y) begin
                     state <= DONE;
                     done  <= 1'b1;
                     ovf   <= 1'b1;
                     x     <= 8'hFF;
                     r     <= 8'hFF;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               a   <= a_next;
               q   <= q_next;
               cnt <= cnt + 3'd1;
               if (cnt == LAST_CNT) begin
                  state <= DONE;
                  done  <= 1'b1;
                  x     <= x_next;
                  r     <= a_next;
                  ovf   <= 1'b0;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
